// File: rtl/pipeline_stage_buffer.sv
// Elastic DEPTH-entry stage buffer with valid/ready on both sides, flush (discard)
// and squash (keep but neutralise through KILL_MASK).

module pipeline_stage_buffer_entry #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] KILL_MASK = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             kill,
  input  logic             in_invalid,
  input  logic [WIDTH-1:0] in_data,
  output logic             q_invalid,
  output logic [WIDTH-1:0] q_data
);
  // A write already carries the squash flag in in_invalid, so it wins over kill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_invalid <= 1'b0;
      q_data    <= '0;
    end else if (wr_en) begin
      q_invalid <= in_invalid;
      q_data    <= in_invalid ? (in_data & ~KILL_MASK) : in_data;
    end else if (kill) begin
      q_invalid <= 1'b1;
      q_data    <= q_data & ~KILL_MASK;
    end
  end
endmodule

module pipeline_stage_buffer #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] KILL_MASK = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       squash,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_invalid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_invalid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]                 rd_ptr, wr_ptr;
  logic [CW-1:0]                 cnt;
  logic                          push, pop, in_kill;
  logic [DEPTH-1:0]              wr_en, kill, q_inv;
  logic [DEPTH-1:0][WIDTH-1:0]   q_data;

  // in_ready looks only at registered occupancy: no out_ready -> in_ready path.
  assign in_ready  = (cnt != CW'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign in_kill   = in_invalid | squash;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Slot i is live when its distance from the head is below the occupancy.
  function automatic logic occupied(input int i);
    int off;
    off = (i + DEPTH - int'(rd_ptr)) % DEPTH;
    return off < int'(cnt);
  endfunction

  always_comb begin
    wr_en = '0;
    kill  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en[i] = push && (wr_ptr == PW'(i));
      kill[i]  = squash && !flush && occupied(i) && !(pop && (rd_ptr == PW'(i)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    pipeline_stage_buffer_entry #(.WIDTH(WIDTH), .KILL_MASK(KILL_MASK)) u_ent (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en[g]),
      .kill       (kill[g]),
      .in_invalid (in_kill),
      .in_data    (in_data),
      .q_invalid  (q_inv[g]),
      .q_data     (q_data[g])
    );
  end

  assign out_data    = out_valid ? q_data[rd_ptr] : '0;
  assign out_invalid = out_valid ? q_inv[rd_ptr]  : 1'b0;
  assign count       = cnt;
endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// Scoreboard bench: a DEPTH=2 and a DEPTH=4 instance, stimulus queues expected
// head values, per-instance monitors pop and compare on each consumed head.

module tb_pipeline_stage_buffer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic f2 = 0, s2 = 0, iv2 = 0, ii2 = 0, or2 = 0;
  logic [W-1:0] id2 = '0;
  logic ir2, ov2, oi2;
  logic [W-1:0] od2;
  logic [1:0] c2;

  logic f4 = 0, s4 = 0, iv4 = 0, ii4 = 0, or4 = 0;
  logic [W-1:0] id4 = '0;
  logic ir4, ov4, oi4;
  logic [W-1:0] od4;
  logic [2:0] c4;

  pipeline_stage_buffer #(.WIDTH(W), .DEPTH(2), .KILL_MASK(32'h1)) d2 (
    .clk(clk), .rst_n(rst_n), .flush(f2), .squash(s2),
    .in_valid(iv2), .in_ready(ir2), .in_invalid(ii2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_invalid(oi2), .out_data(od2), .count(c2));

  pipeline_stage_buffer #(.WIDTH(W), .DEPTH(4), .KILL_MASK(32'h1)) d4 (
    .clk(clk), .rst_n(rst_n), .flush(f4), .squash(s4),
    .in_valid(iv4), .in_ready(ir4), .in_invalid(ii4), .in_data(id4),
    .out_valid(ov4), .out_ready(or4), .out_invalid(oi4), .out_data(od4), .count(c4));

  typedef struct { logic inv; logic [W-1:0] data; } exp_t;
  exp_t q2[$], q4[$];
  exp_t e2, e4;
  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Monitors: a head consumed at the coming edge must match the queue front.
  always @(negedge clk) begin
    if (rst_n && ov2 && or2 && !f2) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL d2_unexpected: got %0h want none", od2);
      end else begin
        e2 = q2.pop_front();
        chk("d2_data", od2, e2.data);
        chk("d2_inv", oi2, e2.inv);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov4 && or4 && !f4) begin
      if (q4.size() == 0) begin
        total++; bad++;
        $display("FAIL d4_unexpected: got %0h want none", od4);
      end else begin
        e4 = q4.pop_front();
        chk("d4_data", od4, e4.data);
        chk("d4_inv", oi4, e4.inv);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_ov", ov2, 0);
    chk("rst_oi", oi2, 0);
    chk("rst_od", od2, 0);
    chk("rst_cnt", c2, 0);
    chk("rst_ir", ir2, 1);
    chk("rst_cnt4", c4, 0);
    rst_n = 1'b1;
    cyc();

    // Streaming on DEPTH=2: each push is the head one cycle later
    or2 = 1;
    for (int i = 0; i < 8; i++) begin
      iv2 = 1; ii2 = 0; id2 = 32'h11 + i;
      q2.push_back('{1'b0, 32'h11 + i});
      cyc();
      chk("stream_head", od2, 32'h11 + i);
      chk("stream_cnt", c2, 1);
      chk("stream_ir", ir2, 1);
    end
    iv2 = 0;
    cyc();
    chk("stream_empty", c2, 0);

    // Backpressure fill
    or2 = 0;
    iv2 = 1; id2 = 32'hA; q2.push_back('{1'b0, 32'hA}); cyc();
    id2 = 32'hB; q2.push_back('{1'b0, 32'hB}); cyc();
    id2 = 32'hC;
    chk("bp_full_cnt", c2, 2);
    chk("bp_full_ir", ir2, 0);
    cyc();
    chk("bp_no_accept", c2, 2);
    chk("bp_head_a", od2, 32'hA);
    iv2 = 0; or2 = 1;
    cyc();
    or2 = 0;
    chk("bp_ir_back", ir2, 1);
    chk("bp_cnt1", c2, 1);
    chk("bp_head_b", od2, 32'hB);
    or2 = 1; cyc(); or2 = 0;
    chk("bp_drained", c2, 0);

    // Kill mask on an invalid push
    iv2 = 1; ii2 = 1; id2 = 32'hFF;
    q2.push_back('{1'b1, 32'hFE});
    cyc();
    iv2 = 0; ii2 = 0;
    chk("kill_data", od2, 32'hFE);
    chk("kill_inv", oi2, 1);
    or2 = 1; cyc(); or2 = 0;

    // Squash on DEPTH=4: two held entries plus a same-cycle push
    iv4 = 1; id4 = 32'h3; q4.push_back('{1'b1, 32'h2}); cyc();
    id4 = 32'h5; q4.push_back('{1'b1, 32'h4}); cyc();
    chk("sq_pre_inv", oi4, 0);
    chk("sq_pre_data", od4, 32'h3);
    id4 = 32'h7; s4 = 1; q4.push_back('{1'b1, 32'h6}); cyc();
    iv4 = 0; s4 = 0;
    chk("sq_cnt", c4, 3);
    chk("sq_head", od4, 32'h2);
    chk("sq_head_inv", oi4, 1);
    or4 = 1; cyc(); cyc(); cyc(); or4 = 0;
    chk("sq_drained", c4, 0);

    // Flush with simultaneous push, pop and squash
    iv4 = 1;
    for (int i = 1; i <= 3; i++) begin id4 = i; cyc(); end
    chk("fl_pre_cnt", c4, 3);
    f4 = 1; s4 = 1; or4 = 1; id4 = 32'h44;
    cyc();
    f4 = 0; s4 = 0; or4 = 0; iv4 = 0;
    chk("fl_cnt", c4, 0);
    chk("fl_ov", ov4, 0);
    chk("fl_od", od4, 0);
    iv4 = 1; id4 = 32'h9; q4.push_back('{1'b0, 32'h9}); cyc();
    iv4 = 0;
    chk("fl_post_data", od4, 32'h9);
    chk("fl_post_inv", oi4, 0);
    chk("fl_post_cnt", c4, 1);
    or4 = 1; cyc(); or4 = 0;

    // Asynchronous reset between edges with two entries held
    iv2 = 1; id2 = 32'h21; cyc();
    id2 = 32'h22; cyc();
    iv2 = 0;
    chk("ar_pre_cnt", c2, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cnt", c2, 0);
    chk("ar_ov", ov2, 0);
    chk("ar_od", od2, 0);
    chk("ar_ir", ir2, 1);
    #1 rst_n = 1'b1;
    iv2 = 1; id2 = 32'h5A; q2.push_back('{1'b0, 32'h5A}); cyc();
    iv2 = 0;
    chk("ar_first_push", od2, 32'h5A);
    or2 = 1; cyc(); or2 = 0;
    cyc();

    chk("q2_empty", q2.size(), 0);
    chk("q4_empty", q4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
